// File: rtl/bp_trace_arbiter_if.sv
// Nexus trace packet type plus the source-side and sink-side handshake
// interfaces used by bp_trace_arbiter.
package bp_trace_pkg;
   localparam logic [5:0] MCODE_DIRECT_BRANCH = 6'd3;
   localparam logic [5:0] MCODE_COMPRESSED    = 6'd29;

   typedef struct packed {
      logic [5:0]  mcode;
      logic [15:0] timestamp;
      logic [63:0] addr;
   } nexus_trace_pkt_s;
endpackage

interface bp_trace_src_if import bp_trace_pkg::*; #(parameter int NUM_SRC = 4);
   nexus_trace_pkt_s [NUM_SRC-1:0] src_pkt_i;
   logic [NUM_SRC-1:0]             src_valid_i;
   logic [NUM_SRC-1:0]             src_ready_o;

   modport master (output src_pkt_i, output src_valid_i, input src_ready_o);
   modport slave  (input src_pkt_i, input src_valid_i, output src_ready_o);
endinterface

interface bp_trace_sink_if import bp_trace_pkg::*; #(parameter int SRC_ID_W = 2);
   nexus_trace_pkt_s    trace_pkt_o;
   logic [SRC_ID_W-1:0] trace_src_o;
   logic                trace_valid_o;
   logic                trace_ready_i;

   modport master (output trace_pkt_o, output trace_src_o, output trace_valid_o, input trace_ready_i);
   modport slave  (input trace_pkt_o, input trace_src_o, input trace_valid_o, output trace_ready_i);
endinterface

// File: rtl/bp_trace_arbiter.sv
// Round-robin arbiter sharing one Nexus trace sink between NUM_SRC encoders;
// disabled sources are drained and their packets counted as drops.
module bp_trace_arbiter import bp_trace_pkg::*; #(
   parameter int NUM_SRC    = 4,
   parameter int SRC_ID_W   = $clog2(NUM_SRC),
   parameter int DROP_CNT_W = 16
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   bp_trace_src_if.slave                       src,
   bp_trace_sink_if.master                     sink,
   input  logic [NUM_SRC-1:0]                  src_en_i,
   input  logic                                drop_clr_i,
   output logic [NUM_SRC-1:0][DROP_CNT_W-1:0]  drop_cnt_o
);

   logic                load_p0;
   logic [NUM_SRC-1:0]  cand_p0;
   logic [NUM_SRC-1:0]  grant_p0;
   logic                found_p0;
   logic [SRC_ID_W-1:0] gnt_idx_p0;
   logic [SRC_ID_W-1:0] rr_next_p0;
   logic [SRC_ID_W-1:0] scan_idx;
   int                  scan_sum;

   logic [SRC_ID_W-1:0] rr_ptr;
   logic                vld_p1;
   nexus_trace_pkt_s    pkt_p1;
   logic [SRC_ID_W-1:0] src_p1;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + DROP_CNT_W'(1);
   endfunction

   // p0: pick the first candidate at or after the round-robin pointer
   always_comb begin
      load_p0    = !vld_p1 || sink.trace_ready_i;
      cand_p0    = src.src_valid_i & src_en_i;
      grant_p0   = '0;
      found_p0   = 1'b0;
      gnt_idx_p0 = '0;
      scan_idx   = '0;
      scan_sum   = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         scan_sum = int'(rr_ptr) + k;
         if (scan_sum >= NUM_SRC) scan_sum = scan_sum - NUM_SRC;
         scan_idx = SRC_ID_W'(scan_sum);
         if (!found_p0 && cand_p0[scan_idx]) begin
            found_p0           = 1'b1;
            gnt_idx_p0         = scan_idx;
            grant_p0[scan_idx] = 1'b1;
         end
      end
      rr_next_p0 = (gnt_idx_p0 == SRC_ID_W'(NUM_SRC-1)) ? '0 : gnt_idx_p0 + SRC_ID_W'(1);
   end

   // Disabled sources are always ready so a masked core is never stalled.
   assign src.src_ready_o = ~src_en_i | (grant_p0 & {NUM_SRC{load_p0}});

   // p1: single output register, reloaded whenever empty or being drained
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vld_p1 <= 1'b0;
         pkt_p1 <= '0;
         src_p1 <= '0;
         rr_ptr <= '0;
      end else if (load_p0) begin
         vld_p1 <= found_p0;
         if (found_p0) begin
            pkt_p1 <= src.src_pkt_i[gnt_idx_p0];
            src_p1 <= gnt_idx_p0;
            rr_ptr <= rr_next_p0;
         end
      end
   end

   assign sink.trace_valid_o = vld_p1;
   assign sink.trace_pkt_o   = pkt_p1;
   assign sink.trace_src_o   = src_p1;

   always_ff @(posedge clk_i) begin
      if (reset_i || drop_clr_i) begin
         drop_cnt_o <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src.src_valid_i[i] && !src_en_i[i]) drop_cnt_o[i] <= sat_inc(drop_cnt_o[i]);
         end
      end
   end

endmodule

// File: tb/tb_bp_trace_arbiter.sv
// Directed-vector bench for bp_trace_arbiter; a second instance with a
// 4-bit drop counter shares the source stimulus to check saturation.
module tb_bp_trace_arbiter;
   import bp_trace_pkg::*;

   logic clk = 1'b0;
   logic reset_i;
   logic [3:0] src_en;
   logic drop_clr;
   logic [3:0][15:0] drop1;
   logic [3:0][3:0]  drop2;
   int vectors = 0;
   int miscompares = 0;
   nexus_trace_pkt_s pkts [4];

   bp_trace_src_if  #(.NUM_SRC(4))  s1();
   bp_trace_sink_if #(.SRC_ID_W(2)) k1();
   bp_trace_src_if  #(.NUM_SRC(4))  s2();
   bp_trace_sink_if #(.SRC_ID_W(2)) k2();

   assign s2.src_pkt_i     = s1.src_pkt_i;
   assign s2.src_valid_i   = s1.src_valid_i;
   assign k2.trace_ready_i = 1'b1;

   bp_trace_arbiter #(.NUM_SRC(4), .SRC_ID_W(2), .DROP_CNT_W(16)) dut (
      .clk_i(clk), .reset_i(reset_i), .src(s1), .sink(k1),
      .src_en_i(src_en), .drop_clr_i(drop_clr), .drop_cnt_o(drop1));

   bp_trace_arbiter #(.NUM_SRC(4), .SRC_ID_W(2), .DROP_CNT_W(4)) dut_sat (
      .clk_i(clk), .reset_i(reset_i), .src(s2), .sink(k2),
      .src_en_i(src_en), .drop_clr_i(drop_clr), .drop_cnt_o(drop2));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      s1.src_valid_i = 4'b1111;
      src_en = 4'b1111;
      k1.trace_ready_i = 1'b1;
      drop_clr = 1'b0;
      repeat (2) tick();
      vectors++;
      if (k1.trace_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL reset_valid: got %b want 0", k1.trace_valid_o);
      end
      vectors++;
      if (k1.trace_pkt_o !== '0 || k1.trace_src_o !== 2'd0) begin
         miscompares++; $display("FAIL reset_pkt: got pkt %h src %0d want 0 / 0", k1.trace_pkt_o, k1.trace_src_o);
      end
      vectors++;
      if (drop1 !== '0 || drop2 !== '0) begin
         miscompares++; $display("FAIL reset_drop: got %h / %h want 0", drop1, drop2);
      end
      reset_i = 1'b0;
      #1;
      vectors++;
      if (s1.src_ready_o !== 4'b0001) begin
         miscompares++; $display("FAIL first_ready: got %b want 0001", s1.src_ready_o);
      end
      tick();
      vectors++;
      if (k1.trace_valid_o !== 1'b1 || k1.trace_src_o !== 2'd0 || k1.trace_pkt_o !== pkts[0]) begin
         miscompares++; $display("FAIL first_grant: got v%b src %0d pkt %h want v1 src 0 pkt %h",
                                 k1.trace_valid_o, k1.trace_src_o, k1.trace_pkt_o, pkts[0]);
      end
   endtask

   task automatic test_round_robin();
      for (int k = 1; k <= 8; k++) begin
         logic [1:0] exp;
         logic [3:0] exp_rdy;
         exp = 2'(k % 4);
         exp_rdy = 4'b0001 << exp;
         vectors++;
         if (s1.src_ready_o !== exp_rdy) begin
            miscompares++; $display("FAIL rr_ready[%0d]: got %b want %b", k, s1.src_ready_o, exp_rdy);
         end
         tick();
         vectors++;
         if (k1.trace_valid_o !== 1'b1 || k1.trace_src_o !== exp || k1.trace_pkt_o !== pkts[exp]) begin
            miscompares++; $display("FAIL rr_src[%0d]: got v%b src %0d want v1 src %0d",
                                    k, k1.trace_valid_o, k1.trace_src_o, exp);
         end
      end
   endtask

   task automatic test_stall();
      s1.src_valid_i = 4'b0000;
      tick();
      vectors++;
      if (k1.trace_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL drain_valid: got %b want 0", k1.trace_valid_o);
      end
      pkts[1] = '{mcode: MCODE_COMPRESSED, timestamp: 16'h0042, addr: 64'h10};
      s1.src_pkt_i[1] = pkts[1];
      s1.src_valid_i = 4'b0010;
      #1;
      vectors++;
      if (s1.src_ready_o !== 4'b0010) begin
         miscompares++; $display("FAIL stall_accept_ready: got %b want 0010", s1.src_ready_o);
      end
      tick();
      s1.src_valid_i = 4'b1111;
      k1.trace_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (s1.src_ready_o !== 4'b0000) begin
            miscompares++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, s1.src_ready_o);
         end
         tick();
         vectors++;
         if (k1.trace_valid_o !== 1'b1 || k1.trace_src_o !== 2'd1 || k1.trace_pkt_o !== pkts[1]) begin
            miscompares++; $display("FAIL stall_hold[%0d]: got v%b src %0d pkt %h want v1 src 1 pkt %h",
                                    c, k1.trace_valid_o, k1.trace_src_o, k1.trace_pkt_o, pkts[1]);
         end
      end
      s1.src_valid_i = 4'b0000;
      k1.trace_ready_i = 1'b1;
      tick();
      vectors++;
      if (k1.trace_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL stall_once: got valid %b want 0", k1.trace_valid_o);
      end
   endtask

   task automatic test_reset_mid_stall();
      s1.src_valid_i = 4'b0100;
      k1.trace_ready_i = 1'b0;
      tick();
      s1.src_valid_i = 4'b0000;
      tick();
      vectors++;
      if (k1.trace_valid_o !== 1'b1 || k1.trace_src_o !== 2'd2) begin
         miscompares++; $display("FAIL pre_reset_hold: got v%b src %0d want v1 src 2", k1.trace_valid_o, k1.trace_src_o);
      end
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      k1.trace_ready_i = 1'b1;
      vectors++;
      if (k1.trace_valid_o !== 1'b0 || k1.trace_pkt_o !== '0) begin
         miscompares++; $display("FAIL reset_discard: got v%b pkt %h want v0 pkt 0", k1.trace_valid_o, k1.trace_pkt_o);
      end
   endtask

   task automatic test_mask();
      src_en = 4'b1101;
      s1.src_valid_i = 4'b0011;
      for (int c = 0; c < 5; c++) begin
         #1;
         vectors++;
         if (s1.src_ready_o !== 4'b0011) begin
            miscompares++; $display("FAIL mask_ready[%0d]: got %b want 0011", c, s1.src_ready_o);
         end
         tick();
         vectors++;
         if (k1.trace_valid_o !== 1'b1 || k1.trace_src_o !== 2'd0) begin
            miscompares++; $display("FAIL mask_src[%0d]: got v%b src %0d want v1 src 0", c, k1.trace_valid_o, k1.trace_src_o);
         end
      end
      vectors++;
      if (drop1[1] !== 16'd5 || drop1[0] !== 16'd0 || drop2[1] !== 4'd5) begin
         miscompares++; $display("FAIL drop_count: got %0d (src0 %0d, narrow %0d) want 5 (0, 5)", drop1[1], drop1[0], drop2[1]);
      end
      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      vectors++;
      if (drop1[1] !== 16'd0 || drop2[1] !== 4'd0) begin
         miscompares++; $display("FAIL drop_clear: got %0d / %0d want 0 / 0", drop1[1], drop2[1]);
      end
   endtask

   task automatic test_saturate();
      repeat (20) tick();
      vectors++;
      if (drop2[1] !== 4'd15) begin
         miscompares++; $display("FAIL drop_saturate: got %0d want 15", drop2[1]);
      end
      vectors++;
      if (drop1[1] !== 16'd20) begin
         miscompares++; $display("FAIL drop_wide: got %0d want 20", drop1[1]);
      end
   endtask

   task automatic test_wrap();
      src_en = 4'b1111;
      s1.src_valid_i = 4'b0000;
      tick();
      pkts[3] = '{mcode: MCODE_DIRECT_BRANCH, timestamp: 16'hBEEF, addr: 64'hFFFF_FFFF_8000_0000};
      s1.src_pkt_i[3] = pkts[3];
      s1.src_valid_i = 4'b1000;
      tick();
      vectors++;
      if (k1.trace_valid_o !== 1'b1 || k1.trace_src_o !== 2'd3 || k1.trace_pkt_o !== pkts[3]) begin
         miscompares++; $display("FAIL wrap_src3: got v%b src %0d pkt %h want v1 src 3 pkt %h",
                                 k1.trace_valid_o, k1.trace_src_o, k1.trace_pkt_o, pkts[3]);
      end
      s1.src_valid_i = 4'b1001;
      tick();
      vectors++;
      if (k1.trace_src_o !== 2'd0 || k1.trace_pkt_o !== pkts[0]) begin
         miscompares++; $display("FAIL wrap_src0: got src %0d want 0", k1.trace_src_o);
      end
      tick();
      vectors++;
      if (k1.trace_src_o !== 2'd3 || k1.trace_pkt_o.addr !== 64'hFFFF_FFFF_8000_0000) begin
         miscompares++; $display("FAIL wrap_back3: got src %0d addr %h want 3 / ffffffff80000000",
                                 k1.trace_src_o, k1.trace_pkt_o.addr);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         pkts[i].mcode     = 6'(i + 1);
         pkts[i].timestamp = 16'(16'h0100 + i);
         pkts[i].addr      = 64'hA000_0000_0000_0000 | 64'(i);
         s1.src_pkt_i[i]   = pkts[i];
      end
      test_reset();
      test_round_robin();
      test_stall();
      test_reset_mid_stall();
      test_mask();
      test_saturate();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
